// File: rtl/keypad_entry_peripheral.sv
// Keypad number-entry peripheral: debounces four keys and builds a signed decimal value digit by digit.
// The value is latched into a CPU data register on enter, with a valid/ack handshake and a sticky overrun flag.
module keypad_entry_peripheral #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int MAX_DIGITS      = 9
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [3:0]         sw_digit,
   input  logic               key_digit_n,
   input  logic               key_neg_n,
   input  logic               key_clr_n,
   input  logic               key_enter_n,
   input  logic               rd_ack,
   output logic signed [31:0] entry,
   output logic signed [31:0] data,
   output logic               data_valid,
   output logic               overrun,
   output logic [3:0]         digit_count
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam int K_DIGIT = 0;
   localparam int K_NEG   = 1;
   localparam int K_CLR   = 2;
   localparam int K_ENTER = 3;

   function automatic logic signed [31:0] apply_sign(input logic [31:0] m, input logic s);
      return s ? -$signed(m) : $signed(m);
   endfunction

   logic [3:0]    key_n;
   logic [3:0]    sync_p0, sync_p1, deb_p2, deb_dly_p2, press_p3;
   logic [CW-1:0] cnt_p2 [4];
   logic [31:0]   mag;
   logic          sign;
   logic [3:0]    count;
   logic          digit_ok;
   logic [31:0]   mag_next;

   assign key_n = {key_enter_n, key_clr_n, key_neg_n, key_digit_n};

   // p0/p1: synchronizer, p2: debounce, p3: registered press events
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_p0    <= '1;
         sync_p1    <= '1;
         deb_p2     <= '1;
         deb_dly_p2 <= '1;
         press_p3   <= '0;
         for (int i = 0; i < 4; i++) cnt_p2[i] <= '0;
      end else begin
         sync_p0    <= key_n;
         sync_p1    <= sync_p0;
         deb_dly_p2 <= deb_p2;
         press_p3   <= deb_dly_p2 & ~deb_p2;
         for (int i = 0; i < 4; i++) begin
            if (sync_p1[i] != deb_p2[i]) begin
               if (cnt_p2[i] == CNT_LAST) begin
                  deb_p2[i] <= sync_p1[i];
                  cnt_p2[i] <= '0;
               end else begin
                  cnt_p2[i] <= cnt_p2[i] + 1'b1;
               end
            end else begin
               cnt_p2[i] <= '0;
            end
         end
      end
   end

   assign digit_ok = (sw_digit <= 4'd9) && (count < 4'(MAX_DIGITS));
   assign mag_next = mag * 32'd10 + {28'd0, sw_digit};

   // Only the highest-priority event in a cycle acts: clr > enter > neg > digit
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mag   <= '0;
         sign  <= 1'b0;
         count <= '0;
      end else if (press_p3[K_CLR] || press_p3[K_ENTER]) begin
         mag   <= '0;
         sign  <= 1'b0;
         count <= '0;
      end else if (press_p3[K_NEG]) begin
         sign <= ~sign;
      end else if (press_p3[K_DIGIT] && digit_ok) begin
         mag   <= mag_next;
         count <= count + 4'd1;
      end
   end

   // An enter in the same cycle as rd_ack keeps the new data valid
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data       <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (press_p3[K_ENTER] && !press_p3[K_CLR]) begin
         data       <= entry;
         data_valid <= 1'b1;
         if (rd_ack)
            overrun <= 1'b0;
         else if (data_valid)
            overrun <= 1'b1;
      end else if (rd_ack) begin
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

   assign entry       = apply_sign(mag, sign);
   assign digit_count = count;

endmodule
